// File: rtl/pipe_rca_adder.sv
// -----------------------------------------------------------------------------
// pipe_rca_adder
//
// Purpose:
//   Skewed ripple-carry adder pipeline. The WIDTH-bit add is split into
//   STAGES = WIDTH/CHUNK chunks; stage k adds operand chunk k together with
//   the registered carry out of stage k-1 (stage 0 uses ci). Input skew
//   registers delay chunk k by k cycles so it meets its carry. Output deskew
//   registers delay result chunk k by STAGES-1-k cycles so a whole beat
//   leaves together. Latency is STAGES cycles, throughput one beat per cycle.
//
// Parameters:
//   WIDTH     operand / sum width in bits (must be a multiple of CHUNK)
//   CHUNK     bits added per pipeline stage
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   rst_n     asynchronous active-low reset
//   in_valid  operand beat valid
//   in_ready  block accepts a beat this cycle
//   a, b      unsigned operands
//   ci        carry-in
//   out_valid result valid
//   out_ready consumer accepts the result
//   sum       a+b+ci mod 2^WIDTH
//   co        carry-out of a+b+ci
//   ovf       signed overflow (only when PIPE_RCA_OVF_EN is defined)
//
// Handshake: a transfer happens on an edge where valid && ready are both 1.
//   The whole pipeline advances together on adv = !out_valid || out_ready;
//   in_ready is adv, so a stalled output freezes every register and the
//   presented result stays stable until it is taken.
//
// Build option:
//   PIPE_RCA_OVF_EN  adds output ovf (carry into MSB XOR co), aligned with sum.
// -----------------------------------------------------------------------------
module pipe_rca_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             co
`ifdef PIPE_RCA_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int STAGES = WIDTH / CHUNK;

   logic adv;

   // Per-stage views, each element driven from its own generate iteration.
   logic [CHUNK-1:0] a_stg   [STAGES];
   logic [CHUNK-1:0] b_stg   [STAGES];
   logic [CHUNK-1:0] res_out [STAGES];
   logic             stg_carry [STAGES];
   logic             stg_valid [STAGES];

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int DLY_OUT = STAGES - 1 - k;

      logic             cin;
      logic             vin;
      logic [CHUNK:0]   add;
      logic [CHUNK-1:0] res_q;
      logic             carry_q;
      logic             valid_q;

      if (k == 0) begin : g_first
         // Chunk 0 is used in the cycle it is accepted.
         assign a_stg[k] = a[CHUNK-1:0];
         assign b_stg[k] = b[CHUNK-1:0];
         assign cin      = ci;
         assign vin      = in_valid;
      end else begin : g_skew
         // k-deep delay line so chunk k arrives together with carry k-1.
         logic [k-1:0][CHUNK-1:0] a_sk;
         logic [k-1:0][CHUNK-1:0] b_sk;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_sk <= '0;
               b_sk <= '0;
            end else if (adv) begin
               a_sk[0] <= a[k*CHUNK +: CHUNK];
               b_sk[0] <= b[k*CHUNK +: CHUNK];
               for (int d = 1; d < k; d++) begin
                  a_sk[d] <= a_sk[d-1];
                  b_sk[d] <= b_sk[d-1];
               end
            end
         end

         assign a_stg[k] = a_sk[k-1];
         assign b_stg[k] = b_sk[k-1];
         assign cin      = stg_carry[k-1];
         assign vin      = stg_valid[k-1];
      end

      // Only CHUNK full-adder bits in this path; the carry leaves registered.
      assign add = {1'b0, a_stg[k]} + {1'b0, b_stg[k]} + {{CHUNK{1'b0}}, cin};

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            res_q   <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
         end else if (adv) begin
            res_q   <= add[CHUNK-1:0];
            carry_q <= add[CHUNK];
            valid_q <= vin;
         end
      end

      assign stg_carry[k] = carry_q;
      assign stg_valid[k] = valid_q;

      if (DLY_OUT > 0) begin : g_deskew
         // Early chunks wait here until the last chunk of their beat is done.
         logic [DLY_OUT-1:0][CHUNK-1:0] dsk;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               dsk <= '0;
            end else if (adv) begin
               dsk[0] <= res_q;
               for (int d = 1; d < DLY_OUT; d++) begin
                  dsk[d] <= dsk[d-1];
               end
            end
         end

         assign res_out[k] = dsk[DLY_OUT-1];
      end else begin : g_no_deskew
         assign res_out[k] = res_q;
      end

      assign sum[k*CHUNK +: CHUNK] = res_out[k];

`ifdef PIPE_RCA_OVF_EN
      if (k == STAGES - 1) begin : g_ovf
         // Carry into the MSB recovered from the MSB's own sum bit.
         logic msb_cin;
         assign msb_cin = a_stg[k][CHUNK-1] ^ b_stg[k][CHUNK-1] ^ add[CHUNK-1];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf <= 1'b0;
            end else if (adv) begin
               ovf <= msb_cin ^ add[CHUNK];
            end
         end
      end
`endif
   end

   assign co        = stg_carry[STAGES-1];
   assign out_valid = stg_valid[STAGES-1];

endmodule

// File: tb/tb_pipe_rca_adder.sv
// -----------------------------------------------------------------------------
// tb_pipe_rca_adder
//
// Bench for pipe_rca_adder at WIDTH=16, CHUNK=4. Directed vectors with
// hand-computed results are pushed into exp_q as they are accepted; a monitor
// pops and compares every presented-and-taken result. Covers reset state,
// latency, carry/overflow corner cases, a back-to-back burst, an output
// stall and a mid-stream reset.
// -----------------------------------------------------------------------------
module tb_pipe_rca_adder;

   localparam int WIDTH = 16;
   localparam int CHUNK = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             co;
`ifdef PIPE_RCA_OVF_EN
   logic             ovf;
`endif

   pipe_rca_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .ci        (ci),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .co        (co)
`ifdef PIPE_RCA_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   // ---------------- scoreboard state ----------------
   // Expected entry layout: {ovf, co, sum}
   logic [17:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int n_out  = 0;
   int run    = 0;
   int max_run = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- driver ----------------
   // Presents a beat and waits (bounded) for it to be accepted; the expected
   // result is queued on the cycle the handshake is seen.
   task automatic drive_beat(input logic [15:0] av, input logic [15:0] bv,
                             input logic civ, input logic [17:0] expv);
      bit acc = 0;
      int n = 0;
      a = av;
      b = bv;
      ci = civ;
      in_valid = 1'b1;
      while (!acc && n < 50) begin
         @(negedge clk);
         if (in_ready) begin
            acc = 1;
            exp_q.push_back(expv);
         end
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: beat a=%h b=%h not accepted in 50 cycles", av, bv);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [17:0] e;
      if (rst_n && out_valid) begin
         run++;
         if (run > max_run) max_run = run;
      end else begin
         run = 0;
      end
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: sum=%h co=%b with empty queue", sum, co);
         end else begin
            e = exp_q.pop_front();
            check("sum", {16'h0, sum}, {16'h0, e[15:0]});
            check("co", {31'h0, co}, {31'h0, e[16]});
`ifdef PIPE_RCA_OVF_EN
            check("ovf", {31'h0, ovf}, {31'h0, e[17]});
`endif
            n_out++;
         end
      end
   end

   // ---------------- burst vectors ----------------
   logic [15:0] va [10];
   logic [15:0] vb [10];
   logic        vc [10];
   logic [17:0] ve [10];

   initial begin
      va[0] = 16'h1234; vb[0] = 16'h4321; vc[0] = 0; ve[0] = 18'h05555;
      va[1] = 16'hFFFF; vb[1] = 16'h0001; vc[1] = 0; ve[1] = 18'h10000;
      va[2] = 16'h8000; vb[2] = 16'h8000; vc[2] = 0; ve[2] = 18'h30000;
      va[3] = 16'h0F0F; vb[3] = 16'hF0F0; vc[3] = 1; ve[3] = 18'h10000;
      va[4] = 16'hABCD; vb[4] = 16'h1111; vc[4] = 1; ve[4] = 18'h0BCDF;
      va[5] = 16'h7FFF; vb[5] = 16'h0001; vc[5] = 0; ve[5] = 18'h28000;
      va[6] = 16'h0000; vb[6] = 16'h0000; vc[6] = 1; ve[6] = 18'h00001;
      va[7] = 16'hAAAA; vb[7] = 16'h5555; vc[7] = 0; ve[7] = 18'h0FFFF;
      va[8] = 16'hFFFF; vb[8] = 16'hFFFF; vc[8] = 1; ve[8] = 18'h1FFFF;
      va[9] = 16'h0FFF; vb[9] = 16'h0001; vc[9] = 0; ve[9] = 18'h01000;
   end

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int lat;
      int n;
      int seen;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      ci        = 1'b0;
      out_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", {31'h0, out_valid}, 32'h0);
      check("rst_in_ready", {31'h0, in_ready}, 32'h1);
      check("rst_sum", {16'h0, sum}, 32'h0);
      check("rst_co", {31'h0, co}, 32'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single beat, latency 4
      drive_beat(16'h00FF, 16'h0001, 1'b0, 18'h00100);
      in_valid = 1'b0;
      check("lat_not_early", {31'h0, out_valid}, 32'h0);
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("latency", lat, 32'd4);
      repeat (6) @(posedge clk);
      #1;

      // All-ones carry-through and signed overflow
      drive_beat(16'hFFFF, 16'h0000, 1'b1, 18'h10000);
      drive_beat(16'h7FFF, 16'h0001, 1'b0, 18'h28000);
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;

      // Ten back-to-back beats
      max_run = 0;
      for (int i = 0; i < 10; i++) begin
         drive_beat(va[i], vb[i], vc[i], ve[i]);
      end
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("burst_run", max_run, 32'd10);

      // Output stall for 3 cycles with a beat waiting at the input
      out_ready = 1'b0;
      drive_beat(16'h1111, 16'h2222, 1'b0, 18'h03333);
      drive_beat(16'hF000, 16'h1000, 1'b0, 18'h10000);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("stall_valid_seen", {31'h0, out_valid}, 32'h1);
      fork
         drive_beat(16'h0101, 16'h0202, 1'b1, 18'h00304);
         begin
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               check("stall_in_ready", {31'h0, in_ready}, 32'h0);
               check("stall_out_valid", {31'h0, out_valid}, 32'h1);
               check("stall_sum", {16'h0, sum}, 32'h3333);
               check("stall_co", {31'h0, co}, 32'h0);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;

      // Mid-stream reset: one result presented, three more in flight
      drive_beat(16'h0001, 16'h0001, 1'b0, 18'h00002);
      drive_beat(16'h0003, 16'h0004, 1'b0, 18'h00007);
      drive_beat(16'h0010, 16'h0020, 1'b0, 18'h00030);
      drive_beat(16'h0100, 16'h0200, 1'b0, 18'h00300);
      in_valid = 1'b0;
      check("pre_reset_valid", {31'h0, out_valid}, 32'h1);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("async_rst_out_valid", {31'h0, out_valid}, 32'h0);
      check("async_rst_in_ready", {31'h0, in_ready}, 32'h1);
      check("async_rst_sum", {16'h0, sum}, 32'h0);
      check("async_rst_co", {31'h0, co}, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("post_reset_stale", seen, 32'd0);

      // Final accounting: 1 + 2 + 10 + 3 results taken before the reset test
      check("queue_empty", exp_q.size(), 32'd0);
      check("outputs_taken", n_out, 32'd16);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
